// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl
// Sequences one integer divide (DIV / DIVU) at a time through an external
// fixed-latency divider and presents the quotient / remainder to the HI/LO
// writeback.
//
// Handshake rules:
//   * Divide-by-zero skips the divider. The result is LO = all ones and
//     HI = dividend.
//   * A divider that never answers is caught by a saturating wait counter.
//     It raises the sticky timeout_err and returns a zero result.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   flush                 synchronous pipeline flush (returns to IDLE, keeps results)
//   req_valid/req_ready   request handshake from EX
//   req_signed            1 = DIV, 0 = DIVU
//   req_dividend/divisor  32-bit operands
//   div_ce                one-cycle start pulse to the divider
//   div_dividend/divisor  operands held stable while the divider works
//   div_is_signed         operation type held stable while the divider works
//   div_ce_done           divider completion strobe
//   div_quotient/remainder divider results
//   wb_allin              writeback can take the result this cycle
//   hilo_we               HI/LO write strobe
//   lo_out / hi_out       quotient / remainder presented to HI/LO
//   busy                  stall request to issue
//   timeout_err           sticky divider-timeout flag
module hilo_div_ctrl #(
  parameter int LATENCY       = 17,
  parameter int TIMEOUT_SLACK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  input  logic        req_signed,
  input  logic [31:0] req_dividend,
  input  logic [31:0] req_divisor,
  output logic        req_ready,
  output logic        div_ce,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_is_signed,
  input  logic        div_ce_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        wb_allin,
  output logic        hilo_we,
  output logic [31:0] lo_out,
  output logic [31:0] hi_out,
  output logic        busy,
  output logic        timeout_err
);

  localparam int DATA_W = 32;
  localparam int LIMIT  = LATENCY + TIMEOUT_SLACK;
  localparam int CNT_W  = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              div_zero;
  logic              timeout_hit;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Flush blocks acceptance.
  assign accept   = (state == IDLE) && req_valid && !flush;
  assign div_zero = (req_divisor == '0);

  // The timeout fires when the counter is about to reach its limit. The zero
  // result is then in DONE on the cycle the counter would have hit
  // LATENCY+TIMEOUT_SLACK, which is 2+LATENCY+TIMEOUT_SLACK cycles after
  // accept.
  assign timeout_hit = (state == WAIT) && !div_ce_done && (cnt >= CNT_LAST);

  // Flush and reset both cancel the start pulse and the writeback strobe of
  // the cycle in which they are asserted.
  assign div_ce  = (state == ISSUE) && !flush && !reset;
  assign hilo_we = (state == DONE) && wb_allin && !flush && !reset;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = div_zero ? DONE : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (div_ce_done || timeout_hit) state_nxt = DONE;
      DONE:    if (wb_allin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      div_is_signed <= 1'b0;
      lo_out        <= '0;
      hi_out        <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!flush) begin
        case (state)
          IDLE: begin
            if (req_valid) begin
              if (div_zero) begin
                lo_out <= {DATA_W{1'b1}};
                hi_out <= req_dividend;
              end else begin
                div_dividend  <= req_dividend;
                div_divisor   <= req_divisor;
                div_is_signed <= req_signed;
              end
            end
          end
          ISSUE: cnt <= '0;
          WAIT: begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (div_ce_done) begin
              lo_out <= div_quotient;
              hi_out <= div_remainder;
            end else if (timeout_hit) begin
              timeout_err <= 1'b1;
              lo_out      <= '0;
              hi_out      <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/hilo_div_ctrl.md
HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

Interface
REQ-001 The block SHALL have parameter LATENCY, default 17, meaning the cycle count from div_ce high to div_ce_done high.
REQ-002 The block SHALL have parameter TIMEOUT_SLACK, default 4, meaning the extra cycles beyond LATENCY tolerated before a timeout.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; port names are clk and reset.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  pipeline flush; synchronous, same effect as reset on state.
- req_valid  in  1  divide request from EX.
- req_signed  in  1  1 = DIV (signed), 0 = DIVU.
- req_dividend  in  32  dividend.
- req_divisor  in  32  divisor.
- req_ready  out  1  request accepted when req_valid && req_ready.
- div_ce  out  1  CE_in to divider, one-cycle pulse.
- div_dividend  out  32  operand to divider.
- div_divisor  out  32  operand to divider.
- div_is_signed  out  1  op type to divider.
- div_ce_done  in  1  CE_out from divider.
- div_quotient  in  32  divider quotient.
- div_remainder  in  32  divider remainder.
- wb_allin  in  1  writeback accepts this cycle.
- hilo_we  out  1  HI/LO write strobe.
- lo_out  out  32  quotient result.
- hi_out  out  32  remainder result.
- busy  out  1  stall request to issue.
- timeout_err  out  1  sticky divider-timeout flag.

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-005 req_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-006 In IDLE, an accept with req_divisor!=0 SHALL register the operands and req_signed, then go to ISSUE.
REQ-007 In IDLE, an accept with req_divisor==0 SHALL bypass the divider: lo_out<=32'hFFFF_FFFF, hi_out<=req_dividend, go to DONE, no div_ce.
REQ-008 div_ce SHALL be 1 for exactly the single ISSUE cycle, after which the state goes to WAIT and the counter clears to 0.
REQ-009 div_dividend, div_divisor and div_is_signed SHALL stay constant from ISSUE until the state leaves WAIT.
REQ-010 In WAIT the counter SHALL increment each cycle and saturate at LATENCY+TIMEOUT_SLACK.
REQ-011 div_ce_done SHALL be honoured only in WAIT; when high, the block SHALL set lo_out<=div_quotient and hi_out<=div_remainder, then go to DONE.
REQ-012 When div_ce_done is ignored in IDLE, ISSUE or DONE, no output SHALL change.
REQ-013 In WAIT, if the counter reaches LATENCY+TIMEOUT_SLACK without div_ce_done, the block SHALL set timeout_err<=1, lo_out<=0 and hi_out<=0, then go to DONE.
REQ-014 hilo_we SHALL be combinational, equal to (state==DONE) && wb_allin.
REQ-015 DONE SHALL go to IDLE on the cycle hilo_we is 1; otherwise DONE SHALL hold with lo_out and hi_out stable.
REQ-016 Back-to-back requests: a new request SHALL be accepted no earlier than the cycle after DONE exits; one op in flight maximum.
REQ-017 Nominal latency SHALL be: accept at cycle 0, div_ce at 1, div_ce_done at 1+LATENCY, results valid in DONE at 2+LATENCY (cycle 19 for default), hilo_we the same cycle if wb_allin=1.
REQ-018 flush in any state SHALL force IDLE next cycle and suppress hilo_we and div_ce in that cycle.
REQ-019 flush SHALL leave lo_out, hi_out and timeout_err unchanged.
REQ-020 When reset and flush are both high, reset SHALL take priority.
REQ-021 When req_valid and flush are both high in IDLE, the request SHALL NOT be accepted.

Reset
REQ-022 On reset=1 at a clock edge: state=IDLE, counter=0, div_ce=0, div_dividend=0, div_divisor=0, div_is_signed=0, lo_out=0, hi_out=0, timeout_err=0.
REQ-023 Reset mid-operation (ISSUE, WAIT or DONE) SHALL abandon the op with no hilo_we, and a later div_ce_done SHALL be ignored.

Verification
REQ-024 Unsigned 100/7, divider model latency 17, wb_allin=1 -> div_ce at cycle 1, hilo_we at cycle 19, lo_out=14, hi_out=2.
REQ-025 Signed -7/2 (32'hFFFF_FFF9, 2) -> div_is_signed=1, lo_out=32'hFFFF_FFFD, hi_out=32'hFFFF_FFFF.
REQ-026 Divisor 0, dividend 32'h1234 -> no div_ce, DONE at cycle 1, lo_out=32'hFFFF_FFFF, hi_out=32'h1234.
REQ-027 wb_allin=0 for 5 cycles after results are valid -> busy=1, results held, hilo_we pulses once when wb_allin rises.
REQ-028 flush at cycle 10 of WAIT, with div_ce_done still arriving at cycle 18 -> IDLE at cycle 11, no hilo_we, lo_out and hi_out unchanged.
REQ-029 Divider model never asserts div_ce_done -> timeout_err=1 at cycle 2+LATENCY+TIMEOUT_SLACK, lo_out=0, hi_out=0, one hilo_we.
